// File: rtl/switch_pkg.sv
// Shared defaults and the counter-width helper for the switch debouncer bank.
package switch_pkg;

  localparam int NUM_CH_DEF     = 8;
  localparam int STABLE_CNT_DEF = 3;

  // ceil(log2(stable_cnt)) with a floor of 1 bit; valid for stable_cnt 2..255
  function automatic int cnt_width(input int stable_cnt);
    int w;
    w = 1;
    for (int i = 1; i < 9; i++)
      if ((1 << i) < stable_cnt) w = i + 1;
    return w;
  endfunction

endpackage

// File: rtl/switch_chan.sv
// Single debounce channel: disagreement counter, debounced state and edge pulses.
module switch_chan
  import switch_pkg::*;
#(
  parameter int STABLE_CNT = STABLE_CNT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic sample,
  output logic state,
  output logic rise,
  output logic fall
);

  localparam int              CW      = cnt_width(STABLE_CNT);
  localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CNT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (tick) begin
        if (sample == state) begin
          cnt <= '0;
        end else if (cnt == CNT_MAX) begin
          // the STABLE_CNT-th consecutive disagreeing tick commits the change
          state <= ~state;
          cnt   <= '0;
          rise  <= ~state;
          fall  <= state;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/switch_bank.sv
// Bank of NUM_CH independent switch debouncers sharing one sample tick.
// Define SWITCH_BANK_SYNC_EN to insert a two-flop synchroniser on every switch input.
module switch_bank
  import switch_pkg::*;
#(
  parameter int NUM_CH     = NUM_CH_DEF,
  parameter int STABLE_CNT = STABLE_CNT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              debounce_clk,
  input  logic [NUM_CH-1:0] switch,
  output logic [NUM_CH-1:0] state,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall
);

  logic [NUM_CH-1:0] sample;

`ifdef SWITCH_BANK_SYNC_EN
  logic [NUM_CH-1:0] sync_p0;
  logic [NUM_CH-1:0] sync_p1;

  // synchroniser runs every clk, independent of the sample tick
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= switch;
      sync_p1 <= sync_p0;
    end
  end

  assign sample = sync_p1;
`else
  assign sample = switch;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    switch_chan #(
      .STABLE_CNT(STABLE_CNT)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .tick  (debounce_clk),
      .sample(sample[g]),
      .state (state[g]),
      .rise  (rise[g]),
      .fall  (fall[g])
    );
  end

endmodule

// File: tb/tb_switch_bank.sv
// Self-checking bench for switch_bank (NUM_CH=8, STABLE_CNT=3): vector table, scoreboard, corner sequences.
module tb_switch_bank;

  localparam int NCH    = 8;
  localparam int STABLE = 3;
`ifdef SWITCH_BANK_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           debounce_clk;
  logic [NCH-1:0] switch;
  logic [NCH-1:0] state, rise, fall;

  switch_bank #(.NUM_CH(NCH), .STABLE_CNT(STABLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .debounce_clk(debounce_clk),
    .switch      (switch),
    .state       (state),
    .rise        (rise),
    .fall        (fall)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [NCH-1:0] st;
    logic [NCH-1:0] ri;
    logic [NCH-1:0] fa;
  } out_t;

  out_t sb_q[$];

  // reference model state
  logic       m_state [NCH];
  logic       m_rise  [NCH];
  logic       m_fall  [NCH];
  logic       m_s1    [NCH];
  logic       m_s2    [NCH];
  int         m_run   [NCH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural reference: count consecutive disagreeing ticks, commit at STABLE
  task automatic model_edge(input logic r, input logic [NCH-1:0] sw, input logic tk);
    out_t e;
    for (int c = 0; c < NCH; c++) begin
      logic smp;
      smp = SYNC ? m_s2[c] : sw[c];
      m_rise[c] = 1'b0;
      m_fall[c] = 1'b0;
      if (r) begin
        m_state[c] = 1'b0;
        m_run[c]   = 0;
        m_s1[c]    = 1'b0;
        m_s2[c]    = 1'b0;
      end else begin
        m_s2[c] = m_s1[c];
        m_s1[c] = sw[c];
        if (tk) begin
          if (smp == m_state[c]) begin
            m_run[c] = 0;
          end else begin
            m_run[c] = m_run[c] + 1;
            if (m_run[c] >= STABLE) begin
              m_run[c]   = 0;
              m_state[c] = smp;
              m_rise[c]  = smp;
              m_fall[c]  = ~smp;
            end
          end
        end
      end
      e.st[c] = m_state[c];
      e.ri[c] = m_rise[c];
      e.fa[c] = m_fall[c];
    end
    sb_q.push_back(e);
  endtask

  // drive one cycle, score against the model after the edge
  task automatic cyc(input logic r, input logic [NCH-1:0] sw, input logic tk);
    out_t e;
    rst          = r;
    switch       = sw;
    debounce_clk = tk;
    model_edge(r, sw, tk);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_empty at %0t", $time);
    end else begin
      e = sb_q.pop_front();
      check("sb_state", 32'(state), 32'(e.st));
      check("sb_rise",  32'(rise),  32'(e.ri));
      check("sb_fall",  32'(fall),  32'(e.fa));
      check("rise_and_fall_overlap", 32'(rise & fall), 32'd0);
    end
  endtask

  typedef struct {
    logic [NCH-1:0] sw;
    logic           tk;
    logic [NCH-1:0] exp_st;
    logic [NCH-1:0] exp_ri;
    logic [NCH-1:0] exp_fa;
  } vec_t;

  vec_t vecs[18];

  initial begin
    logic [NCH-1:0] hold_st;
    int             bad;

    vecs[0]  = '{8'hA5, 1'b1, 8'h00, 8'h00, 8'h00};
    vecs[1]  = '{8'hA5, 1'b1, 8'h00, 8'h00, 8'h00};
    vecs[2]  = '{8'hA5, 1'b1, 8'hA5, 8'hA5, 8'h00};
    vecs[3]  = '{8'hA5, 1'b1, 8'hA5, 8'h00, 8'h00};
    vecs[4]  = '{8'h00, 1'b1, 8'hA5, 8'h00, 8'h00};
    vecs[5]  = '{8'h00, 1'b1, 8'hA5, 8'h00, 8'h00};
    vecs[6]  = '{8'h00, 1'b1, 8'h00, 8'h00, 8'hA5};
    vecs[7]  = '{8'h00, 1'b1, 8'h00, 8'h00, 8'h00};
    vecs[8]  = '{8'hFF, 1'b0, 8'h00, 8'h00, 8'h00};
    vecs[9]  = '{8'hFF, 1'b1, 8'h00, 8'h00, 8'h00};
    vecs[10] = '{8'hFF, 1'b0, 8'h00, 8'h00, 8'h00};
    vecs[11] = '{8'hFF, 1'b1, 8'h00, 8'h00, 8'h00};
    vecs[12] = '{8'h0F, 1'b1, 8'h0F, 8'h0F, 8'h00};
    vecs[13] = '{8'hFF, 1'b1, 8'h0F, 8'h00, 8'h00};
    vecs[14] = '{8'hFF, 1'b1, 8'h0F, 8'h00, 8'h00};
    vecs[15] = '{8'hF0, 1'b1, 8'hFF, 8'hF0, 8'h00};
    vecs[16] = '{8'hF0, 1'b1, 8'hFF, 8'h00, 8'h00};
    vecs[17] = '{8'hF0, 1'b1, 8'hF0, 8'h00, 8'h0F};

    // reset with a tick present: reset must win
    cyc(1'b1, 8'hFF, 1'b1);
    cyc(1'b1, 8'hFF, 1'b1);
    check("reset_state", 32'(state), 32'd0);
    check("reset_pulses", 32'({rise, fall}), 32'd0);
    cyc(1'b0, 8'h00, 1'b0);

`ifndef SWITCH_BANK_SYNC_EN
    // table: back-to-back ticks, mixed channels
    for (int i = 0; i < 18; i++) begin
      cyc(1'b0, vecs[i].sw, vecs[i].tk);
      check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].exp_st));
      check($sformatf("vec%0d_rise", i),  32'(rise),  32'(vecs[i].exp_ri));
      check($sformatf("vec%0d_fall", i),  32'(fall),  32'(vecs[i].exp_fa));
    end

    // sparse ticks every 4 clk, ch0 held high
    cyc(1'b1, 8'h00, 1'b0);
    for (int t = 0; t < 3; t++) begin
      cyc(1'b0, 8'h01, 1'b1);
      if (t < 2) check("sparse_state_early", 32'(state[0]), 32'd0);
      else begin
        check("sparse_state_set", 32'(state[0]), 32'd1);
        check("sparse_rise", 32'(rise[0]), 32'd1);
        check("sparse_fall", 32'(fall), 32'd0);
      end
      for (int k = 0; k < 3; k++) begin
        cyc(1'b0, 8'h01, 1'b0);
        if (t == 2 && k == 0) check("sparse_rise_one_cycle", 32'(rise[0]), 32'd0);
      end
    end

    // glitch: 2 high, 1 low, then 3 high needed
    cyc(1'b1, 8'h00, 1'b0);
    cyc(1'b0, 8'h01, 1'b1);
    cyc(1'b0, 8'h01, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    check("glitch_state", 32'(state[0]), 32'd0);
    cyc(1'b0, 8'h01, 1'b1);
    cyc(1'b0, 8'h01, 1'b1);
    check("glitch_two_more", 32'(state[0]), 32'd0);
    cyc(1'b0, 8'h01, 1'b1);
    check("glitch_third", 32'(state[0]), 32'd1);
    check("glitch_rise", 32'(rise[0]), 32'd1);

    // reset mid-count discards progress
    cyc(1'b1, 8'h00, 1'b0);
    cyc(1'b0, 8'h01, 1'b1);
    cyc(1'b0, 8'h01, 1'b1);
    cyc(1'b1, 8'h01, 1'b1);
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_pulse", 32'({rise, fall}), 32'd0);
    cyc(1'b0, 8'h01, 1'b1);
    cyc(1'b0, 8'h01, 1'b1);
    check("midrst_after2", 32'({state[0], rise[0]}), 32'd0);
    cyc(1'b0, 8'h01, 1'b1);
    check("midrst_after3", 32'({state[0], rise[0]}), 32'd3);
`endif

    // no ticks for 100 cycles while switches toggle
    hold_st = state;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b0, NCH'($urandom), 1'b0);
      if (state !== hold_st || rise !== '0 || fall !== '0) bad++;
    end
    check("idle_100_changes", 32'(bad), 32'd0);

    // random traffic: mostly-stable inputs with occasional flips, random tick density
    begin
      logic [NCH-1:0] sw;
      sw = '0;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 3) == 0) sw = sw ^ NCH'($urandom);
        cyc(1'b0, sw, 1'($urandom_range(0, 2) != 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_bank.md
SWITCH_BANK -- requirements
Module: switch_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of independent switch channels (1..32).
REQ-002 SHALL have parameter STABLE_CNT, default 3, consecutive agreeing ticks required to change a channel's state (2..255).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port debounce_clk  input  1  sample-tick enable, one clk cycle wide, arbitrary period.
REQ-006 SHALL have port switch  input  NUM_CH  raw switch levels, asynchronous to clk.
REQ-007 SHALL have port state  output  NUM_CH  debounced level per channel, registered.
REQ-008 SHALL have port rise  output  NUM_CH  one-cycle pulse when state bit goes 0->1, registered.
REQ-009 SHALL have port fall  output  NUM_CH  one-cycle pulse when state bit goes 1->0, registered.

Function
REQ-010 Each channel SHALL be processed independently; no cross-channel interaction.
REQ-011 Per channel, sample = conditioned switch bit (see Configuration); a counter of width ceil(log2(STABLE_CNT)) SHALL track consecutive ticks where sample != state.
REQ-012 On a clk edge with debounce_clk=1 and sample == state: counter SHALL clear to 0.
REQ-013 On a clk edge with debounce_clk=1, sample != state, counter < STABLE_CNT-1: counter SHALL increment by 1.
REQ-014 On a clk edge with debounce_clk=1, sample != state, counter == STABLE_CNT-1: state SHALL invert, counter SHALL clear, and rise or fall (per new value) SHALL assert for exactly that following cycle.
REQ-015 With debounce_clk=0: state and counter SHALL hold; rise and fall SHALL be 0.
REQ-016 Latency: a clean input change SHALL appear on state in the cycle after the STABLE_CNT-th qualifying tick (plus sync delay if enabled).
REQ-017 A single disagreeing tick followed by an agreeing tick SHALL reset progress; glitches shorter than STABLE_CNT ticks SHALL never reach state.
REQ-018 Counter SHALL never wrap; it is bounded at STABLE_CNT-1 by REQ-014.
REQ-019 rise and fall for the same channel SHALL never assert together; rise/fall bits of different channels MAY assert in the same cycle.
REQ-020 Back-to-back debounce_clk (every cycle) SHALL be legal and behave identically to sparse ticks.

Reset
REQ-021 rst=1 on a clk edge SHALL force state=0, rise=0, fall=0, all counters=0, all synchroniser flops=0, regardless of debounce_clk.
REQ-022 Reset mid-count SHALL discard progress; after rst deasserts, a held-high switch SHALL need a full STABLE_CNT ticks to set state, producing one rise pulse.
REQ-023 Reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-024 Macro SWITCH_BANK_SYNC_EN defined: each switch bit SHALL pass through a two-flop synchroniser clocked every clk (not tick-gated) before use as sample; adds 2 cycles latency.
REQ-025 Macro SWITCH_BANK_SYNC_EN undefined: sample SHALL be the switch bit directly; caller guarantees synchronous input.

Structure
REQ-026 Package switch_pkg SHALL hold STABLE_CNT default, NUM_CH default, and the counter-width function.
REQ-027 Per-channel logic SHALL be sub-module switch_chan (counter, state, rise/fall), instantiated NUM_CH times by generate; synchroniser lives in switch_bank.

Verification
REQ-028 STABLE_CNT=3, no sync, ticks every 4 clk, ch0 switch 0->1 held -> state[0]=1 after third tick, rise[0]=1 for one cycle, fall=0.
REQ-029 Same setup, ch0 high for 2 ticks then low for 1 then high -> state[0] stays 0 until 3 further consecutive high ticks.
REQ-030 NUM_CH=8, switch=8'hA5 held, debounce_clk every cycle -> state=8'hA5 on cycle 4, rise=8'hA5 that cycle only; then switch=8'h00 -> fall=8'hA5 three ticks later.
REQ-031 rst asserted after 2 of 3 qualifying ticks -> state=0, no pulse; after release, 3 more ticks needed before rise.
REQ-032 debounce_clk=0 for 100 cycles while switch toggles -> state, rise, fall unchanged/zero.
REQ-033 SWITCH_BANK_SYNC_EN defined, debounce_clk every cycle, STABLE_CNT=2 -> state follows switch edge after exactly 4 clk cycles.
